// File: rtl/shadow_writer_pkg.sv
// shadow_writer_pkg: shared types and reset constant for the shadowed control-register writer
package shadow_writer_pkg;
  typedef enum logic [2:0] {
    ST_IDLE,
    ST_STAGE,
    ST_COMMIT,
    ST_CHECK,
    ST_RESP
  } state_e;
  typedef enum logic [1:0] {
    RESP_OK,
    RESP_SKIP,
    RESP_UPDATE_ERR,
    RESP_READBACK_ERR
  } resp_e;
  typedef struct packed {
    logic force_zero_masks;
    logic manual_operation;
  } ctrl_reg_t;
  localparam ctrl_reg_t CTRL_RESET = '{force_zero_masks: 1'b1, manual_operation: 1'b0};
endpackage

// File: rtl/shadow_reg_writer.sv
// shadow_reg_writer: stage/commit write sequencer with readback check, bounded retry and confirmed-value mirror
module shadow_reg_writer
  import shadow_writer_pkg::*;
#(
  parameter int DW = 2,
  parameter logic [DW-1:0] RESVAL = '0,
  parameter int MAX_RETRY = 1
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          req_valid_i,
  output logic          req_ready_o,
  input  logic [DW-1:0] req_data_i,
  output logic          we_o,
  output logic [DW-1:0] wd_o,
  input  logic [DW-1:0] reg_q_i,
  input  logic          reg_update_err_i,
  output logic          resp_valid_o,
  input  logic          resp_ready_i,
  output logic [1:0]    resp_err_o,
  output logic [DW-1:0] mirror_o
);
  localparam logic [1:0] MAX_R = MAX_RETRY[1:0];
  state_e state;
  resp_e err_q;
  logic [DW-1:0] data_q, mirror_q;
  logic [1:0] retry_q;
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state    <= ST_IDLE;
      err_q    <= RESP_OK;
      data_q   <= '0;
      mirror_q <= RESVAL;
      retry_q  <= '0;
    end else begin
      case (state)
        ST_IDLE: if (req_valid_i) begin
          data_q  <= req_data_i;
          retry_q <= '0;
          err_q   <= RESP_SKIP;
          state   <= (req_data_i == mirror_q) ? ST_RESP : ST_STAGE;
        end
        ST_STAGE:  state <= ST_COMMIT;
        ST_COMMIT: state <= ST_CHECK;
        ST_CHECK: if (reg_update_err_i) begin
          err_q <= RESP_UPDATE_ERR;
          state <= ST_RESP;
        end else if (reg_q_i == data_q) begin
          err_q    <= RESP_OK;
          mirror_q <= data_q;
          state    <= ST_RESP;
        end else if (retry_q < MAX_R) begin
          retry_q <= retry_q + 2'd1;
          state   <= ST_STAGE;
        end else begin
          err_q <= RESP_READBACK_ERR;
          state <= ST_RESP;
        end
        ST_RESP: if (resp_ready_i) state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end
  // every output comes from state or a register, never straight from an input
  assign req_ready_o  = (state == ST_IDLE);
  assign we_o         = (state == ST_STAGE) || (state == ST_COMMIT);
  assign wd_o         = we_o ? data_q : '0;
  assign resp_valid_o = (state == ST_RESP);
  assign resp_err_o   = err_q;
  assign mirror_o     = mirror_q;
endmodule
